// File: rtl/bpu_update_scheduler.sv
// Branch-predictor update scheduler: queues resolved branch updates and drains them one
// per cycle into the predictor. It also runs a flush walk. BPU_MISPRED_STATS_EN adds a
// saturating mispredict counter.
module bpu_update_scheduler #(
  parameter int DEPTH = 4,
  parameter int IDX_W = 4
) (
`ifdef BPU_MISPRED_STATS_EN
  output logic [15:0]      mispred_count,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [15:0]      upd_target,
  input  logic             upd_mispredicted,
  output logic             upd_ready,
  input  logic             flush_req,
  output logic             flush_busy,
  output logic             wr_en,
  output logic [IDX_W-1:0] wr_index,
  output logic             wr_taken,
  output logic             wr_btb_en,
  output logic [15:0]      wr_target,
  output logic             wr_clear
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DRAIN = 2'd1, FLUSH = 2'd2} state_t;
  typedef struct packed {
    logic [IDX_W-1:0] pc;
    logic             taken;
    logic [15:0]      target;
  } upd_t;

  state_t           state_q, state_d;
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, occ;
  logic [IDX_W-1:0] flush_cnt_q, flush_cnt_d;
  upd_t             mem_q [DEPTH];
  upd_t             mem_d [DEPTH];
  upd_t             head;
  logic             empty, full, push, pop, flush_start;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign occ         = wr_ptr_q - rd_ptr_q;
  assign head        = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign flush_start = flush_req && (state_q != FLUSH);
  // A flush request kills the head write of that cycle so no queued entry leaks out.
  assign pop         = (state_q == DRAIN) && !flush_req;
  assign upd_ready   = (state_q != FLUSH) && !flush_req && (!full || pop);
  assign push        = upd_valid && upd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush_start) state_d = FLUSH;
               else if (push) state_d = DRAIN;
      DRAIN:   if (flush_start) state_d = FLUSH;
               else if (!push && occ == (PTR_W+1)'(1)) state_d = IDLE;
      FLUSH:   if (flush_cnt_q == {IDX_W{1'b1}}) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    flush_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (state_q == FLUSH) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end else if (flush_start) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PTR_W-1:0]] = '{pc: upd_pc, taken: upd_taken, target: upd_target};
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    wr_en      = 1'b0;
    wr_index   = '0;
    wr_taken   = 1'b0;
    wr_btb_en  = 1'b0;
    wr_target  = '0;
    wr_clear   = 1'b0;
    flush_busy = (state_q == FLUSH);
    if (state_q == FLUSH) begin
      wr_en     = 1'b1;
      wr_index  = flush_cnt_q;
      wr_btb_en = 1'b1;
      wr_clear  = 1'b1;
    end else if (pop) begin
      wr_en     = 1'b1;
      wr_index  = head.pc;
      wr_taken  = head.taken;
      wr_btb_en = head.taken;
      wr_target = head.target;
    end
  end

`ifdef BPU_MISPRED_STATS_EN
  logic [15:0] mispred_q, mispred_d;

  always_comb begin
    mispred_d = mispred_q;
    if (push && upd_mispredicted && mispred_q != 16'hFFFF) mispred_d = mispred_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mispred_q <= '0;
    else        mispred_q <= mispred_d;
  end

  assign mispred_count = mispred_q;
`endif
endmodule

// File: tb/tb_bpu_update_scheduler.sv
// Randomized bench for bpu_update_scheduler against a queue-based reference model.
module tb_bpu_update_scheduler;
  localparam int DEPTH = 4;
  localparam int IDX_W = 4;
  localparam int N     = 1 << IDX_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             upd_valid, upd_taken, upd_mispredicted, flush_req;
  logic [IDX_W-1:0] upd_pc;
  logic [15:0]      upd_target;
  logic             upd_ready, flush_busy, wr_en, wr_taken, wr_btb_en, wr_clear;
  logic [IDX_W-1:0] wr_index;
  logic [15:0]      wr_target;
`ifdef BPU_MISPRED_STATS_EN
  logic [15:0]      mispred_count;
`endif

  bpu_update_scheduler #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
`ifdef BPU_MISPRED_STATS_EN
    .mispred_count(mispred_count),
`endif
    .clk(clk), .rst_n(rst_n), .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_mispredicted(upd_mispredicted), .upd_ready(upd_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .wr_en(wr_en),
    .wr_index(wr_index), .wr_taken(wr_taken), .wr_btb_en(wr_btb_en),
    .wr_target(wr_target), .wr_clear(wr_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IDX_W-1:0] pc;
    logic             tk;
    logic [15:0]      tg;
  } ent_t;

  ent_t q[$];
  int   flush_left = 0;
  int   mcount     = 0;
  int   total      = 0;
  int   bad        = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    flush_left = 0;
    mcount     = 0;
  endtask

  // One clock: drive at negedge, compare against model, then advance model across posedge.
  task automatic step(input logic v, input logic [IDX_W-1:0] pc, input logic tk,
                      input logic [15:0] tg, input logic mis, input logic fl);
    logic e_en, e_tk, e_btb, e_clr, e_busy, e_rdy;
    logic [IDX_W-1:0] e_idx;
    logic [15:0] e_tg;
    @(negedge clk);
    upd_valid = v; upd_pc = pc; upd_taken = tk; upd_target = tg;
    upd_mispredicted = mis; flush_req = fl;
    #1;
    e_en = 0; e_tk = 0; e_btb = 0; e_clr = 0; e_busy = 0; e_rdy = 0; e_idx = '0; e_tg = '0;
    if (flush_left > 0) begin
      e_en = 1; e_idx = IDX_W'(N - flush_left); e_btb = 1; e_clr = 1; e_busy = 1;
    end else if (!fl) begin
      e_rdy = (q.size() < DEPTH) || (q.size() > 0);
      if (q.size() > 0) begin
        e_en = 1; e_idx = q[0].pc; e_tk = q[0].tk; e_btb = q[0].tk; e_tg = q[0].tg;
      end
    end
    check_eq("wr_en", 32'(wr_en), 32'(e_en));
    check_eq("wr_index", 32'(wr_index), 32'(e_idx));
    check_eq("wr_taken", 32'(wr_taken), 32'(e_tk));
    check_eq("wr_btb_en", 32'(wr_btb_en), 32'(e_btb));
    check_eq("wr_target", 32'(wr_target), 32'(e_tg));
    check_eq("wr_clear", 32'(wr_clear), 32'(e_clr));
    check_eq("flush_busy", 32'(flush_busy), 32'(e_busy));
    check_eq("upd_ready", 32'(upd_ready), 32'(e_rdy));
`ifdef BPU_MISPRED_STATS_EN
    check_eq("mispred_count", 32'(mispred_count), 32'(mcount));
`endif
    if (flush_left > 0) flush_left--;
    else if (fl) begin
      q.delete();
      flush_left = N;
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (v && e_rdy) begin
        q.push_back('{pc: pc, tk: tk, tg: tg});
        if (mis && mcount < 65535) mcount++;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0);
  endtask

  initial begin
    rst_n = 0; upd_valid = 0; upd_pc = '0; upd_taken = 0; upd_target = '0;
    upd_mispredicted = 0; flush_req = 0;
    model_reset();
    #12;
    check_eq("rst_wr_en", 32'(wr_en), 0);
    check_eq("rst_flush_busy", 32'(flush_busy), 0);
    check_eq("rst_upd_ready", 32'(upd_ready), 1);
    check_eq("rst_wr_target", 32'(wr_target), 0);
    @(negedge clk); rst_n = 1;
    idle(2);

    // single taken update
    step(1, 4'h5, 1, 16'h1234, 0, 0);
    check_eq("single_wr_en", 32'(wr_en), 0);
    step(0, '0, 0, '0, 0, 0);
    check_eq("single_wr_index", 32'(wr_index), 5);
    check_eq("single_wr_target", 32'(wr_target), 16'h1234);
    idle(2);

    // five back-to-back updates
    for (int i = 0; i < 5; i++) step(1, IDX_W'(i + 3), i[0], 16'(16'hA000 + i), 0, 0);
    idle(3);

    // flush with queued updates
    for (int i = 0; i < 3; i++) step(1, IDX_W'(i), 1, 16'(16'hB000 + i), 1, 0);
    step(0, '0, 0, '0, 0, 1);
    idle(N + 2);

    // update and flush in the same cycle, flush request during walk is ignored
    step(1, 4'h9, 1, 16'hBEEF, 1, 1);
    step(0, '0, 0, '0, 0, 1);
    idle(N + 2);

    // reset in the middle of a flush walk
    step(0, '0, 0, '0, 0, 1);
    idle(7);
    check_eq("pre_rst_index", 32'(wr_index), 6);
    @(negedge clk);
    rst_n = 0;
    #1;
    check_eq("midflush_rst_wr_en", 32'(wr_en), 0);
    check_eq("midflush_rst_busy", 32'(flush_busy), 0);
    check_eq("midflush_rst_clear", 32'(wr_clear), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    idle(3);

    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, IDX_W'($urandom), 1'($urandom), 16'($urandom),
           1'($urandom), $urandom_range(0, 39) == 0);
    idle(N + 2);

`ifdef BPU_MISPRED_STATS_EN
    @(negedge clk); rst_n = 0; model_reset();
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 70000; i++) step(1, IDX_W'(i), 1'(i), 16'(i), 1, 0);
    idle(2);
    check_eq("mispred_saturated", 32'(mispred_count), 32'h0000FFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
